// File: rtl/ttt_game_engine.sv
// ttt_game_engine: 3x3 tic-tac-toe board, turn order, legality and win/draw detection.
// Optional macro TURN_TIMEOUT_EN adds an idle timeout that forfeits the current turn.
module ttt_game_engine #(
  parameter logic        START_PLAYER   = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 32'd250_000_000
) (
  input  logic       Clk,
  input  logic       rst,
  input  logic [3:0] position,
  input  logic       playX,
  input  logic       playO,
  input  logic       new_game,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic       turn_o,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [3:0] win_line,
  output logic       move_ok,
  output logic       move_err
);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  // Row-major masks: rows 0-2, columns 3-5, main diagonal 6, anti-diagonal 7.
  localparam logic [8:0] LINE_MASKS [8] = '{9'h007, 9'h038, 9'h1C0, 9'h049,
                                           9'h092, 9'h124, 9'h111, 9'h054};

  function automatic logic [3:0] first_win_line(input logic [8:0] b);
    logic [3:0] res;
    res = 4'hF;
    for (int i = 7; i >= 0; i--) begin
      if ((b & LINE_MASKS[i]) == LINE_MASKS[i]) begin
        res = 4'(i);
      end
    end
    return res;
  endfunction

  state_t     state_r, state_s;
  logic [8:0] board_x_r, board_x_s, board_o_r, board_o_s;
  logic       turn_r, turn_s, over_r, over_s;
  logic [1:0] winner_r, winner_s;
  logic [3:0] line_r, line_s;
  logic       ok_r, ok_s, err_r, err_s;
  logic       playx_q_r, playx_q_s, playo_q_r, playo_q_s;
  logic       req_x_s, req_o_s, legal_s;
  logic [8:0] cell_s;
  logic [3:0] line_hit_s;

`ifdef TURN_TIMEOUT_EN
  logic [31:0] cnt_r, cnt_s;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

  assign req_x_s    = playX & ~playx_q_r;
  assign req_o_s    = playO & ~playo_q_r;
  assign cell_s     = 9'd1 << position;
  // The requesting player is O exactly when reqO is the single request.
  assign legal_s    = (position <= 4'd8) && (((board_x_r | board_o_r) & cell_s) == 9'd0)
                      && (req_o_s == turn_r);
  assign line_hit_s = first_win_line(turn_r ? board_o_r : board_x_r);

  // Next-state, board update, result evaluation and pulse generation.
  always_comb begin
    state_s   = state_r;
    board_x_s = board_x_r;
    board_o_s = board_o_r;
    turn_s    = turn_r;
    over_s    = over_r;
    winner_s  = winner_r;
    line_s    = line_r;
    ok_s      = 1'b0;
    err_s     = 1'b0;
    playx_q_s = playX;
    playo_q_s = playO;
`ifdef TURN_TIMEOUT_EN
    cnt_s     = cnt_r;
`endif
    if (new_game) begin
      state_s   = ST_PLAY;
      board_x_s = 9'd0;
      board_o_s = 9'd0;
      turn_s    = START_PLAYER;
      over_s    = 1'b0;
      winner_s  = 2'b00;
      line_s    = 4'hF;
      playx_q_s = 1'b0;
      playo_q_s = 1'b0;
`ifdef TURN_TIMEOUT_EN
      cnt_s     = 32'd0;
`endif
    end else begin
      case (state_r)
        ST_PLAY: begin
          if (req_x_s && req_o_s) begin
            err_s = 1'b1;
          end else if ((req_x_s || req_o_s) && legal_s) begin
            board_x_s = turn_r ? board_x_r : (board_x_r | cell_s);
            board_o_s = turn_r ? (board_o_r | cell_s) : board_o_r;
            ok_s      = 1'b1;
            state_s   = ST_CHECK;
          end else if (req_x_s || req_o_s) begin
            err_s = 1'b1;
          end else begin
            state_s = ST_PLAY;
          end
`ifdef TURN_TIMEOUT_EN
          if (ok_s) begin
            cnt_s = 32'd0;
          end else if (cnt_r == TIMEOUT_CYCLES - 32'd1) begin
            turn_s = ~turn_r;
            err_s  = 1'b1;
            cnt_s  = 32'd0;
          end else begin
            cnt_s = cnt_r + 32'd1;
          end
`endif
        end
        ST_CHECK: begin
          if (line_hit_s != 4'hF) begin
            winner_s = turn_r ? 2'b10 : 2'b01;
            line_s   = line_hit_s;
            over_s   = 1'b1;
            state_s  = ST_OVER;
          end else if ((board_x_r | board_o_r) == 9'h1FF) begin
            winner_s = 2'b11;
            line_s   = 4'hF;
            over_s   = 1'b1;
            state_s  = ST_OVER;
          end else begin
            turn_s  = ~turn_r;
            state_s = ST_PLAY;
          end
        end
        ST_OVER: begin
          state_s = ST_OVER;
        end
        default: begin
          state_s = ST_PLAY;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_PLAY;
      board_x_r <= 9'd0;
      board_o_r <= 9'd0;
      turn_r    <= START_PLAYER;
      over_r    <= 1'b0;
      winner_r  <= 2'b00;
      line_r    <= 4'hF;
      ok_r      <= 1'b0;
      err_r     <= 1'b0;
      playx_q_r <= 1'b0;
      playo_q_r <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      cnt_r     <= 32'd0;
`endif
    end else begin
      state_r   <= state_s;
      board_x_r <= board_x_s;
      board_o_r <= board_o_s;
      turn_r    <= turn_s;
      over_r    <= over_s;
      winner_r  <= winner_s;
      line_r    <= line_s;
      ok_r      <= ok_s;
      err_r     <= err_s;
      playx_q_r <= playx_q_s;
      playo_q_r <= playo_q_s;
`ifdef TURN_TIMEOUT_EN
      cnt_r     <= cnt_s;
`endif
    end
  end

  assign board_x   = board_x_r;
  assign board_o   = board_o_r;
  assign turn_o    = turn_r;
  assign game_over = over_r;
  assign winner    = winner_r;
  assign win_line  = line_r;
  assign move_ok   = ok_r;
  assign move_err  = err_r;

endmodule
